// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared state encoding and counter sizing for the frame controller
package shift_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/frame_shift_stage.sv
// frame_shift_stage: DEPTH-wide LSB-first right-shift register with clear and enable
module frame_shift_stage #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [DEPTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= {bit_in, q[DEPTH-1:1]};
endmodule

// File: rtl/shift_frame_controller.sv
// shift_frame_controller: frames DEPTH serial bits after start and holds the word under valid/ready
module shift_frame_controller
  import shift_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [DEPTH-1:0] frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);
  localparam int CW = cnt_width(DEPTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic hs, clr, en, last;
  always_comb begin
    hs   = frame_valid && frame_ready;
    last = cnt == CW'(DEPTH - 1);
    // a start in SHIFT restarts the frame, so its same-cycle bit is dropped
    en   = state == SHIFT && bit_valid && !start && !abort;
    clr  = abort || (start && (state != HOLD || hs));
    nxt  = abort ? IDLE :
           state == IDLE  ? (start ? SHIFT : IDLE) :
           state == SHIFT ? ((en && last) ? HOLD : SHIFT) :
           state == HOLD  ? (hs ? (start ? SHIFT : IDLE) : HOLD) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= clr ? '0 : en ? cnt + CW'(1) : cnt;
      busy        <= nxt == SHIFT;
      frame_valid <= nxt == HOLD;
      overrun     <= (state == HOLD && bit_valid) || (overrun && !overrun_clr);
    end
  frame_shift_stage #(.DEPTH(DEPTH)) u_stage (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .en(en),
    .bit_in(bit_in),
    .q(frame)
  );
endmodule

// File: tb/tb_shift_frame_controller.sv
// tb_shift_frame_controller: directed stimulus with a frame scoreboard checked at each handshake
module tb_shift_frame_controller;
  logic clk = 0, reset = 1, start = 0, abort = 0, bit_in = 0, bit_valid = 0;
  logic frame_ready = 1, overrun_clr = 0;
  logic [7:0] frame;
  logic frame_valid, busy, overrun;
  int pass_n = 0, tot_n = 0;
  int cyc = 0, vcount = 0, bcount = 0;
  logic prev_fv = 0;
  logic [7:0] sb[$];
  int rise_q[$];
  logic [7:0] model;

  shift_frame_controller #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .bit_in(bit_in),
    .bit_valid(bit_valid), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // monitor: a handshake happens at the next edge whenever valid and ready are both high now
  always @(negedge clk) begin
    if (busy) bcount++;
    if (frame_valid) vcount++;
    if (frame_valid && !prev_fv) rise_q.push_back(cyc);
    prev_fv = frame_valid;
    if (frame_valid && frame_ready) begin
      if (sb.size() == 0) chk("unexpected_frame", {56'd0, frame}, 64'hdead);
      else chk("frame_word", {56'd0, frame}, {56'd0, sb.pop_front()});
    end
  end

  task automatic drive(input logic s, input logic bv, input logic b);
    start = s; bit_valid = bv; bit_in = b;
    @(posedge clk); #1;
    start = 0; bit_valid = 0; bit_in = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) drive(0, 1, d[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_frame", {56'd0, frame}, 64'd0);
    chk("reset_valid", {63'd0, frame_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_overrun", {63'd0, overrun}, 64'd0);
    #9 reset = 0;
    @(posedge clk); #1;

    // single frame, back-to-back bits
    vcount = 0; bcount = 0;
    sb.push_back(8'h4D);
    drive(1, 0, 0);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    send_byte(8'h4D);
    chk("valid_after_last_bit", {63'd0, frame_valid}, 64'd1);
    chk("busy_low_in_hold", {63'd0, busy}, 64'd0);
    idle(3);
    chk("single_valid_cycles", vcount, 1);
    chk("single_busy_cycles", bcount, 8);

    // gapped bits: frame only moves on bit_valid cycles
    sb.push_back(8'h4D);
    model = 8'h00;
    drive(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'h4D;
      drive(0, 1, d[i]);
      model = {d[i], model[7:1]};
      chk("gap_bit", {56'd0, frame}, {56'd0, model});
      drive(0, 0, 1);
      chk("gap_hold", {56'd0, frame}, {56'd0, model});
    end
    idle(2);

    // backpressure and overrun
    frame_ready = 0;
    sb.push_back(8'hFF);
    drive(1, 0, 0);
    send_byte(8'hFF);
    for (int i = 0; i < 3; i++) drive(0, 1, 0);
    chk("bp_frame", {56'd0, frame}, 64'hFF);
    chk("bp_valid", {63'd0, frame_valid}, 64'd1);
    chk("bp_overrun", {63'd0, overrun}, 64'd1);
    drive(1, 0, 0);
    chk("start_in_hold_ignored", {63'd0, busy}, 64'd0);
    overrun_clr = 1;
    drive(0, 1, 0);
    overrun_clr = 0;
    chk("clr_vs_event", {63'd0, overrun}, 64'd1);
    frame_ready = 1;
    drive(0, 0, 0);
    chk("bp_released_valid", {63'd0, frame_valid}, 64'd0);
    chk("bp_released_busy", {63'd0, busy}, 64'd0);
    chk("overrun_sticky", {63'd0, overrun}, 64'd1);
    overrun_clr = 1;
    drive(0, 0, 0);
    overrun_clr = 0;
    chk("overrun_cleared", {63'd0, overrun}, 64'd0);
    idle(2);

    // back-to-back frames, handshake and start share the HOLD cycle
    rise_q.delete();
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    drive(1, 0, 0);
    send_byte(8'hA5);
    drive(1, 0, 0);
    send_byte(8'h3C);
    idle(3);
    chk("b2b_rises", rise_q.size(), 2);
    if (rise_q.size() == 2) chk("b2b_spacing", rise_q[1] - rise_q[0], 9);

    // restart after 5 bits; the bit alongside start is dropped
    sb.push_back(8'h81);
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1);
    drive(1, 1, 1);
    send_byte(8'h81);
    idle(2);

    // abort after 3 bits
    vcount = 0;
    drive(1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1);
    abort = 1;
    drive(0, 0, 0);
    abort = 0;
    chk("abort_frame", {56'd0, frame}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    idle(12);
    chk("abort_no_valid", vcount, 0);

    // asynchronous reset mid-frame
    drive(1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 1);
    chk("pre_reset_frame", {56'd0, frame}, 64'hF0);
    #2 reset = 1;
    #1;
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_frame", {56'd0, frame}, 64'd0);
    #1 reset = 0;
    @(posedge clk); #1;
    sb.push_back(8'h5A);
    drive(1, 0, 0);
    send_byte(8'h5A);
    idle(3);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
